dp_sequencer: RTL

DP_SEQUENCER -- requirements
Module: dp_sequencer

---
 rtl/dp_pkg.sv | 51 +++++
 rtl/dp_sequencer_if.sv | 23 ++
 rtl/dp_decoder.sv | 45 ++++
 rtl/dp_sequencer.sv | 107 ++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared types for the datapath sequencer.
// Covers opcodes, FSM states, ALU encodings, instruction field positions and the decoded control bundle.
package dp_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_LDI1 = 3'b100,
        OP_OUT  = 3'b101,
        OP_BLE  = 3'b110,
        OP_HALT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_e;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int RD_HI  = 12;
    localparam int RD_LO  = 10;
    localparam int RS1_HI = 9;
    localparam int RS1_LO = 7;
    localparam int RS2_HI = 6;
    localparam int RS2_LO = 4;
    localparam int TGT_HI = 3;
    localparam int TGT_LO = 0;

    typedef struct packed {
        logic       rf_src_sel;
        logic [2:0] raddr1;
        logic [2:0] raddr2;
        logic [2:0] waddr;
        logic       we;
        logic       out_en;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/dp_sequencer_if.sv
// Instruction-memory and datapath-control bundle between the sequencer and the datapath.
interface dp_sequencer_if #(parameter int IMEM_AW = 4);
    logic [IMEM_AW-1:0] imem_addr;
    logic [15:0]        imem_data;
    logic               lte;
    logic               RFSrcMuxSel;
    logic [2:0]         RAddr1;
    logic [2:0]         RAddr2;
    logic [2:0]         WAddr;
    logic               we;
    logic               OutPortEn;
    logic [1:0]         ALUop;

    modport master (
        output imem_addr, RFSrcMuxSel, RAddr1, RAddr2, WAddr, we, OutPortEn, ALUop,
        input  imem_data, lte
    );

    modport slave (
        input  imem_addr, RFSrcMuxSel, RAddr1, RAddr2, WAddr, we, OutPortEn, ALUop,
        output imem_data, lte
    );
endinterface

// File: rtl/dp_decoder.sv
// Combinational instruction decoder: IR opcode/register fields to datapath controls.
// The branch target field is consumed by the sequencer, so only bits above it come in here.
module dp_decoder
    import dp_pkg::*;
(
    input  logic [OPC_HI:TGT_HI+1] ir,
    output ctrl_t                  ctrl
);

    op_e op;
    assign op = op_e'(ir[OPC_HI:OPC_LO]);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                case (op)
                    OP_SUB:  ctrl.alu_op = ALU_SUB;
                    OP_AND:  ctrl.alu_op = ALU_AND;
                    OP_OR:   ctrl.alu_op = ALU_OR;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
                ctrl.we     = 1'b1;
                ctrl.waddr  = ir[RD_HI:RD_LO];
                ctrl.raddr1 = ir[RS1_HI:RS1_LO];
                ctrl.raddr2 = ir[RS2_HI:RS2_LO];
            end
            OP_LDI1: begin
                ctrl.rf_src_sel = 1'b1;
                ctrl.we         = 1'b1;
                ctrl.waddr      = ir[RD_HI:RD_LO];
            end
            OP_OUT: begin
                ctrl.raddr1 = ir[RS1_HI:RS1_LO];
                ctrl.out_en = 1'b1;
            end
            OP_BLE: begin
                ctrl.raddr1 = ir[RS1_HI:RS1_LO];
                ctrl.raddr2 = ir[RS2_HI:RS2_LO];
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/dp_sequencer.sv
// Fetch/execute sequencer for the small register datapath, with a per-run watchdog.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | IR <= imem_data at PC, controls idle
//   EXEC  | controls decoded from IR, PC/branch update, watchdog tick
//   DONE  | one-cycle done pulse, err qualifies it
module dp_sequencer
    import dp_pkg::*;
#(
    parameter int IMEM_AW   = 4,
    parameter int WDT_LIMIT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    dp_sequencer_if.master  dp
);

    localparam int WW = $clog2(WDT_LIMIT + 1);

    state_e             state;
    logic [IMEM_AW-1:0] pc;
    logic [15:0]        ir;
    logic [WW-1:0]      wdt;
    ctrl_t              dec_ctrl;
    ctrl_t              ctrl;
    op_e                ir_op;

    assign ir_op = op_e'(ir[OPC_HI:OPC_LO]);

    dp_decoder u_decoder (
        .ir   (ir[OPC_HI:TGT_HI+1]),
        .ctrl (dec_ctrl)
    );

    // Watchdog is a down-counter loaded at start; terminal count 1 marks the last allowed EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            wdt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        wdt   <= WW'(WDT_LIMIT);
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= dp.imem_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    wdt <= wdt - 1'b1;
                    if (ir_op == OP_BLE && dp.lte)
                        pc <= IMEM_AW'(ir[TGT_HI:TGT_LO]);
                    else
                        pc <= pc + 1'b1;
                    if (ir_op == OP_HALT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b0;
                        state <= S_DONE;
                    end else if (wdt == WW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Controls come from registered IR/state, so they switch only on clock edges.
    always_comb begin
        ctrl = '0;
        if (state == S_EXEC)
            ctrl = dec_ctrl;
    end

    assign dp.imem_addr   = pc;
    assign dp.RFSrcMuxSel = ctrl.rf_src_sel;
    assign dp.RAddr1      = ctrl.raddr1;
    assign dp.RAddr2      = ctrl.raddr2;
    assign dp.WAddr       = ctrl.waddr;
    assign dp.we          = ctrl.we;
    assign dp.OutPortEn   = ctrl.out_en;
    assign dp.ALUop       = ctrl.alu_op;

endmodule
